uart_tx_framer: RTL and testbench

Parametrised next-generation UART transmit unit. Buffers DATA_W-bit words in an internal FIFO and serialises each word as a complete frame on one line: start bit, data LSB-first, optional parity, then 1 or 2 stop bits. Adds runtime parity mode, stop-bit count, FIFO level/overflow status and back-to-back framing. Sits between the APB UART register decoder and the serial pin; one bit is emitted per baud_clk cycle.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_sync_fifo.sv | 57 +++++
 rtl/uart_tx_framer.sv | 131 +++++++++++++
 tb/tb_uart_tx_framer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART transmit shared types and constants.
// Parity modes, FSM encoding and default geometry.
package uart_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // x is the XOR reduction of the data word
  function automatic logic parity_bit(
    input logic [1:0] mode,
    input logic       x
  );
    unique case (mode)
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO feeding the UART framer.
// Head word is visible combinationally; pop frees room for a same-edge push.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] head,
  output logic              push_ok,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  cnt;
  logic              do_pop;

  assign full    = cnt == LVL_W'(FIFO_DEPTH);
  assign empty   = cnt == '0;
  assign level   = cnt;
  assign do_pop  = pop && !empty;
  assign push_ok = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: FIFO-buffered words serialised one bit per baud_clk.
// Config is latched at pop; last stop bit can chain straight into a start.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              baud_clk,
  input  logic              rst,
  input  logic              write,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  input  logic              tx_enable,
  output logic              tx_serial,
  output logic              busy,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [LVL_W-1:0]  level,
  output logic              PREADY_W,
  output logic              overflow
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  tx_state_e         state;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  bit_cnt;
  logic [1:0]        mode_q;
  logic              two_q;
  logic              par_q;
  logic              stop_cnt;
  logic              last_stop;
  logic              pop;
  logic              push_ok;

  assign busy      = state != ST_IDLE;
  assign last_stop = !two_q || stop_cnt;
  assign pop = tx_enable && !fifo_empty &&
               (state == ST_IDLE ||
                (state == ST_STOP && last_stop));

  uart_sync_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .LVL_W     (LVL_W)
  ) u_fifo (
    .clk    (baud_clk),
    .rst    (rst),
    .push   (write),
    .pop    (pop),
    .data_in(data_in),
    .head   (head),
    .push_ok(push_ok),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx_serial <= 1'b1;
      shift     <= '0;
      bit_cnt   <= '0;
      mode_q    <= PAR_NONE;
      two_q     <= 1'b0;
      par_q     <= 1'b0;
      stop_cnt  <= 1'b0;
      PREADY_W  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      PREADY_W <= write && push_ok;
      overflow <= write && !push_ok;
      if (pop) begin
        state     <= ST_START;
        tx_serial <= 1'b0;
        shift     <= head;
        mode_q    <= parity_mode;
        two_q     <= two_stop;
        par_q     <= parity_bit(parity_mode, ^head);
        bit_cnt   <= '0;
        stop_cnt  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: tx_serial <= 1'b1;
          ST_START: begin
            state     <= ST_DATA;
            tx_serial <= shift[0];
            shift     <= shift >> 1;
            bit_cnt   <= '0;
          end
          ST_DATA: begin
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              stop_cnt <= 1'b0;
              if (mode_q != PAR_NONE) begin
                state     <= ST_PARITY;
                tx_serial <= par_q;
              end else begin
                state     <= ST_STOP;
                tx_serial <= 1'b1;
              end
            end else begin
              tx_serial <= shift[0];
              shift     <= shift >> 1;
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            state     <= ST_STOP;
            tx_serial <= 1'b1;
            stop_cnt  <= 1'b0;
          end
          ST_STOP: begin
            tx_serial <= 1'b1;
            if (last_stop) state <= ST_IDLE;
            else stop_cnt <= 1'b1;
          end
          default: begin
            state     <= ST_IDLE;
            tx_serial <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer.
// Stimulus queues expected frames; a line monitor decodes and compares.
module tb_uart_tx_framer;

  logic       baud_clk = 1'b0;
  logic       rst;
  logic       write;
  logic [7:0] data_in;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx_enable;
  logic       tx_serial;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] level;
  logic       PREADY_W;
  logic       overflow;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pb;
    logic       ts;
    logic       b2b;
  } frame_t;

  frame_t exp_q[$];
  int     n_chk = 0;
  int     n_pass = 0;
  int     cyc = 0;
  int     aborted = 0;

  uart_tx_framer dut (
    .baud_clk   (baud_clk),
    .rst        (rst),
    .write      (write),
    .data_in    (data_in),
    .parity_mode(parity_mode),
    .two_stop   (two_stop),
    .tx_enable  (tx_enable),
    .tx_serial  (tx_serial),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .level      (level),
    .PREADY_W   (PREADY_W),
    .overflow   (overflow)
  );

  always #5 baud_clk = ~baud_clk;
  always @(posedge baud_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe,
                          input logic pb, input logic ts,
                          input logic b2b);
    frame_t f;
    f.data = d; f.pe = pe; f.pb = pb; f.ts = ts; f.b2b = b2b;
    exp_q.push_back(f);
  endtask

  task automatic wait_idle(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      if (!busy && fifo_empty) break;
      tick();
    end
    chk("drain_timeout", {31'd0, busy | !fifo_empty}, 0);
  endtask

  // Line monitor: a low at a negedge outside a frame is a start bit
  initial begin : monitor
    frame_t      e;
    logic [15:0] got, want;
    int          n, idx, start_cyc, last_end;
    bit          abort, unexp;
    last_end = -10;
    forever begin
      @(negedge baud_clk);
      if (!rst && tx_serial === 1'b0) begin
        start_cyc = cyc;
        unexp = exp_q.size() == 0;
        if (unexp) begin
          chk("unexpected_frame", 1, 0);
          e.data = 8'h00; e.pe = 0; e.pb = 0;
          e.ts = 0; e.b2b = 0;
        end else e = exp_q.pop_front();
        want = '0;
        for (int i = 0; i < 8; i++) want[1+i] = e.data[i];
        idx = 9;
        if (e.pe) begin want[idx] = e.pb; idx++; end
        want[idx] = 1'b1; idx++;
        if (e.ts) begin want[idx] = 1'b1; idx++; end
        n = idx;
        got = '0;
        abort = 0;
        for (int i = 1; i < n; i++) begin
          @(negedge baud_clk);
          if (rst) begin abort = 1; break; end
          got[i] = tx_serial;
        end
        if (abort) aborted++;
        else if (!unexp) begin
          chk($sformatf("frame_bits_%02h", e.data), got, want);
          if (e.b2b) chk("b2b_gap", start_cyc, last_end + 1);
          last_end = cyc;
        end
      end
    end
  end

  initial begin : stim
    rst = 1; write = 0; data_in = '0;
    parity_mode = 2'b00; two_stop = 0; tx_enable = 0;
    tick(); tick();
    chk("rst_tx", tx_serial, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_level", level, 0);
    chk("rst_pready", PREADY_W, 0);
    chk("rst_ovf", overflow, 0);
    rst = 0;
    tick();

    // 0xA5, even parity, one stop
    parity_mode = 2'b01; tx_enable = 1;
    push_exp(8'hA5, 1, 0, 0, 0);
    write = 1; data_in = 8'hA5;
    tick();
    chk("t1_pready", PREADY_W, 1);
    chk("t1_level", level, 1);
    write = 0;
    tick();
    chk("t1_pready_once", PREADY_W, 0);
    chk("t1_busy", busy, 1);
    repeat (11) tick();
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_hold", tx_serial, 1);

    // 0x3C, 0x81, odd parity, two stops, back to back
    tx_enable = 0; parity_mode = 2'b10; two_stop = 1;
    push_exp(8'h3C, 1, 1, 1, 0);
    push_exp(8'h81, 1, 1, 1, 1);
    write = 1; data_in = 8'h3C;
    tick();
    chk("t2_level1", level, 1);
    data_in = 8'h81;
    tick();
    chk("t2_level2", level, 2);
    write = 0; tx_enable = 1;
    tick();
    chk("t2_level_pop", level, 1);
    wait_idle(60);
    chk("t2_level0", level, 0);
    chk("t2_line", tx_serial, 1);

    // Fill with tx disabled, then overflow
    tx_enable = 0; parity_mode = 2'b00; two_stop = 0;
    push_exp(8'h10, 0, 0, 0, 0);
    for (int i = 1; i < 16; i++) push_exp(8'h10 + 8'(i), 0, 0, 0, 1);
    write = 1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'h10 + 8'(i);
      tick();
    end
    chk("t3_full", fifo_full, 1);
    chk("t3_level16", level, 16);
    data_in = 8'hEE;
    tick();
    chk("t3_ovf", overflow, 1);
    chk("t3_no_pready", PREADY_W, 0);
    chk("t3_level_hold", level, 16);
    chk("t3_line", tx_serial, 1);

    // Write coinciding with a pop while full
    push_exp(8'h55, 0, 0, 0, 1);
    data_in = 8'h55; tx_enable = 1;
    tick();
    chk("t4_pready", PREADY_W, 1);
    chk("t4_no_ovf", overflow, 0);
    chk("t4_level", level, 16);
    chk("t4_busy", busy, 1);
    write = 0;
    wait_idle(400);

    // Parity none -> mark switched mid-frame
    push_exp(8'h5A, 0, 0, 0, 0);
    push_exp(8'h0F, 1, 1, 0, 1);
    write = 1; data_in = 8'h5A;
    tick();
    data_in = 8'h0F;
    tick();
    write = 0;
    repeat (3) tick();
    parity_mode = 2'b11;
    wait_idle(60);
    parity_mode = 2'b00;

    // Async reset in the middle of DATA
    tx_enable = 0;
    push_exp(8'h00, 0, 0, 0, 0);
    write = 1; data_in = 8'h00;
    tick();
    data_in = 8'hFF;
    tick();
    write = 0; tx_enable = 1;
    tick();
    repeat (3) tick();
    chk("t6_in_data", tx_serial, 0);
    #2 rst = 1;
    #1;
    chk("t6_rst_tx", tx_serial, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_level", level, 0);
    tick();
    rst = 0;
    repeat (30) tick();
    chk("t6_quiet_busy", busy, 0);
    chk("t6_quiet_tx", tx_serial, 1);
    chk("t6_aborted", aborted, 1);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
